// File: rtl/key_event_decoder_if.sv
// Key event decoder signal bundle.
// master drives the key side, slave is the decoder.
interface key_event_decoder_if;
  logic key_down;
  logic ms10_tick;
  logic short_pulse;
  logic double_pulse;
  logic long_pulse;
  logic hold_active;

  modport master (
    output key_down,
    output ms10_tick,
    input  short_pulse,
    input  double_pulse,
    input  long_pulse,
    input  hold_active
  );

  modport slave (
    input  key_down,
    input  ms10_tick,
    output short_pulse,
    output double_pulse,
    output long_pulse,
    output hold_active
  );
endinterface

// File: rtl/key_event_decoder.sv
// Key gesture decoder: short click, double click,
// long press with auto-repeat, from a debounced key.
module key_event_decoder #(
  parameter int LONG_TICKS = 100,
  parameter int DBL_TICKS  = 30,
  parameter int RPT_TICKS  = 20
) (
  input  logic          clk,
  input  logic          sys_rst_n,
  key_event_decoder_if.slave kif
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] PRESS1    = 3'd1;
  localparam logic [2:0] WAIT2     = 3'd2;
  localparam logic [2:0] PRESS2    = 3'd3;
  localparam logic [2:0] LONG_HOLD = 3'd4;

  localparam logic [7:0] LONG_T = 8'(LONG_TICKS);
  localparam logic [7:0] DBL_T  = 8'(DBL_TICKS);
  localparam logic [7:0] RPT_T  = 8'(RPT_TICKS);

  logic [2:0] state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       key_d_q, key_d_d;
  logic       short_q, short_d;
  logic       dbl_q, dbl_d;
  logic       long_q, long_d;
  logic       hold_q, hold_d;

  logic       rise, fall, tick;
  logic [7:0] cnt_inc;

  assign rise    = kif.key_down & ~key_d_q;
  assign fall    = ~kif.key_down & key_d_q;
  assign tick    = kif.ms10_tick;
  assign cnt_inc = cnt_q + 8'd1;

  // next-state, tick counter and pulse decode; edges beat ticks
  always_comb begin
    key_d_d = kif.key_down;
    state_d = state_q;
    cnt_d   = cnt_q;
    short_d = 1'b0;
    dbl_d   = 1'b0;
    long_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = PRESS1;
          cnt_d   = '0;
        end
      end
      PRESS1: begin
        if (fall) begin
          state_d = WAIT2;
          cnt_d   = '0;
        end else if (tick) begin
          if (cnt_inc == LONG_T) begin
            state_d = LONG_HOLD;
            cnt_d   = '0;
            long_d  = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      WAIT2: begin
        if (rise) begin
          state_d = PRESS2;
          cnt_d   = '0;
          dbl_d   = 1'b1;
        end else if (tick) begin
          if (cnt_inc == DBL_T) begin
            state_d = IDLE;
            cnt_d   = '0;
            short_d = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      PRESS2: begin
        if (fall) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      LONG_HOLD: begin
        if (fall) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (tick) begin
          if (cnt_inc == RPT_T) begin
            cnt_d  = '0;
            long_d = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    hold_d = (state_d == LONG_HOLD);
  end

  // state, counter, key history and registered outputs
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      key_d_q <= 1'b0;
      short_q <= 1'b0;
      dbl_q   <= 1'b0;
      long_q  <= 1'b0;
      hold_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      key_d_q <= key_d_d;
      short_q <= short_d;
      dbl_q   <= dbl_d;
      long_q  <= long_d;
      hold_q  <= hold_d;
    end
  end

  assign kif.short_pulse  = short_q;
  assign kif.double_pulse = dbl_q;
  assign kif.long_pulse   = long_q;
  assign kif.hold_active  = hold_q;

endmodule

// File: tb/tb_key_event_decoder.sv
// Bench for key_event_decoder: gesture-level model,
// per-cycle compare, directed cases and random gestures.
module tb_key_event_decoder;
  localparam int LT = 100;
  localparam int DT = 30;
  localparam int RT = 20;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  key_event_decoder_if kif();

  key_event_decoder #(
    .LONG_TICKS(LT),
    .DBL_TICKS (DT),
    .RPT_TICKS (RT)
  ) dut (
    .clk      (clk),
    .sys_rst_n(rst_n),
    .kif      (kif)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int c_s = 0;
  int c_d = 0;
  int c_l = 0;

  // gesture model: active gesture, presses so far, released,
  // long reached, ticks since press, ticks since release
  bit m_prev, m_act, m_rel, m_long;
  int m_np, m_pt, m_gt;
  bit e_s, e_d, e_l, e_h;
  bit mk, mt, mr, mf;

  task automatic model_step();
    if (!rst_n) begin
      m_prev = 0; m_act = 0; m_rel = 0; m_long = 0;
      m_np = 0; m_pt = 0; m_gt = 0;
      e_s = 0; e_d = 0; e_l = 0; e_h = 0;
    end else begin
      mk = kif.key_down;
      mt = kif.ms10_tick;
      mr = mk & ~m_prev;
      mf = ~mk & m_prev;
      m_prev = mk;
      e_s = 0; e_d = 0; e_l = 0;
      if (!m_act) begin
        if (mr) begin
          m_act = 1; m_np = 1; m_rel = 0;
          m_long = 0; m_pt = 0;
        end
      end else if (m_rel) begin
        if (mr) begin
          m_rel = 0; m_np = 2; e_d = 1;
        end else if (mt) begin
          m_gt++;
          if (m_gt == DT) begin
            e_s = 1; m_act = 0;
          end
        end
      end else if (m_np == 2) begin
        if (mf) m_act = 0;
      end else begin
        if (mf) begin
          if (m_long) m_act = 0;
          else begin
            m_rel = 1; m_gt = 0;
          end
        end else if (mt) begin
          m_pt++;
          if (m_pt == LT) begin
            m_long = 1; e_l = 1;
          end else if (m_pt > LT && (m_pt - LT) % RT == 0) begin
            e_l = 1;
          end
        end
      end
      e_h = m_act && m_long;
    end
  endtask

  always @(posedge clk or negedge rst_n) model_step();

  task automatic cmp_step();
    logic [3:0] got, req;
    got = {kif.short_pulse, kif.double_pulse,
           kif.long_pulse, kif.hold_active};
    req = {e_s, e_d, e_l, e_h};
    n_cmp++;
    if (got !== req) begin
      n_bad++;
      $display("FAIL cycle t=%0t s/d/l/h got %b required %b",
               $time, got, req);
    end
  endtask

  always @(negedge clk) cmp_step();

  task automatic chk(input string nm, input int got, input int req);
    n_cmp++;
    if (got !== req) begin
      n_bad++;
      $display("FAIL %s got %0d required %0d", nm, got, req);
    end
  endtask

  task automatic cyc(input logic k, input logic t);
    kif.key_down  = k;
    kif.ms10_tick = t;
    @(negedge clk);
    if (kif.short_pulse === 1'b1)  c_s++;
    if (kif.double_pulse === 1'b1) c_d++;
    if (kif.long_pulse === 1'b1)   c_l++;
  endtask

  task automatic ticks(input logic k, input int n);
    repeat (n) begin
      cyc(k, 1'b1);
      cyc(k, 1'b0);
    end
  endtask

  function automatic int outs();
    return {28'd0, kif.short_pulse, kif.double_pulse,
            kif.long_pulse, kif.hold_active};
  endfunction

  int s0, d0, l0;

  initial begin
    kif.key_down  = 1'b0;
    kif.ms10_tick = 1'b0;
    #12;
    chk("reset_outputs", outs(), 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(0, 0);
    cyc(0, 0);

    // single short click
    s0 = c_s;
    cyc(1, 0);
    ticks(1, 5);
    cyc(0, 0);
    ticks(0, DT - 1);
    cyc(0, 1);
    chk("short_at_30th_tick", int'(kif.short_pulse), 1);
    cyc(0, 0);
    chk("short_one_wide", int'(kif.short_pulse), 0);
    ticks(0, 5);
    chk("short_count", c_s - s0, 1);

    // double click after 10-tick gap
    s0 = c_s; d0 = c_d;
    cyc(1, 0);
    ticks(1, 5);
    cyc(0, 0);
    ticks(0, 10);
    cyc(1, 0);
    chk("double_after_rise", int'(kif.double_pulse), 1);
    cyc(1, 0);
    chk("double_one_wide", int'(kif.double_pulse), 0);
    ticks(1, 3);
    cyc(0, 0);
    ticks(0, 40);
    chk("double_count", c_d - d0, 1);
    chk("double_no_short", c_s - s0, 0);

    // long press with two repeats
    l0 = c_l;
    cyc(1, 0);
    ticks(1, LT - 1);
    cyc(1, 1);
    chk("long_at_100th_tick", int'(kif.long_pulse), 1);
    chk("hold_set", int'(kif.hold_active), 1);
    cyc(1, 0);
    chk("long_one_wide", int'(kif.long_pulse), 0);
    ticks(1, 2 * RT);
    chk("long_count", c_l - l0, 3);
    chk("hold_still", int'(kif.hold_active), 1);
    cyc(0, 0);
    chk("hold_cleared", int'(kif.hold_active), 0);
    ticks(0, 5);

    // release on the 100th tick
    l0 = c_l; s0 = c_s;
    cyc(1, 0);
    ticks(1, LT - 1);
    cyc(0, 1);
    chk("fall_beats_long", int'(kif.long_pulse), 0);
    chk("fall_no_hold", int'(kif.hold_active), 0);
    ticks(0, DT - 1);
    cyc(0, 1);
    chk("short_after_fall_race", int'(kif.short_pulse), 1);
    cyc(0, 0);
    chk("race_long_count", c_l - l0, 0);

    // reset during WAIT2
    s0 = c_s;
    cyc(1, 0);
    ticks(1, 5);
    cyc(0, 0);
    ticks(0, 15);
    #2 rst_n = 1'b0;
    #1 chk("rst_wait2_outputs", outs(), 0);
    @(negedge clk);
    rst_n = 1'b1;
    ticks(0, 40);
    chk("rst_wait2_no_short", c_s - s0, 0);

    // reset while holding long
    cyc(1, 0);
    ticks(1, LT);
    chk("hold_before_rst", int'(kif.hold_active), 1);
    #2 rst_n = 1'b0;
    #1 chk("rst_hold_outputs", outs(), 0);
    @(negedge clk);
    // key already down at release: first clock is a rise
    rst_n = 1'b1;
    l0 = c_l;
    cyc(1, 0);
    ticks(1, LT - 1);
    cyc(1, 1);
    chk("long_after_rst_rise", int'(kif.long_pulse), 1);
    cyc(0, 0);
    chk("rst_rise_long_count", c_l - l0, 1);
    ticks(0, 5);

    // second rise on the 30th gap tick
    s0 = c_s; d0 = c_d;
    cyc(1, 0);
    ticks(1, 5);
    cyc(0, 0);
    ticks(0, DT - 1);
    cyc(1, 1);
    chk("rise_beats_expiry_dbl", int'(kif.double_pulse), 1);
    chk("rise_beats_expiry_sht", int'(kif.short_pulse), 0);
    cyc(1, 0);
    cyc(0, 0);
    ticks(0, 40);
    chk("race_short_count", c_s - s0, 0);
    chk("race_double_count", c_d - d0, 1);

    // random gestures with occasional reset
    for (int s = 0; s < 160; s++) begin
      int n;
      logic lvl;
      lvl = (s % 2 == 0);
      n = lvl ? int'($urandom_range(1, 260))
              : int'($urandom_range(1, 80));
      for (int i = 0; i < n; i++)
        cyc(lvl, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 24) == 0) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
    end
    cyc(0, 0);
    ticks(0, 40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/key_event_decoder.md
KEY_EVENT_DECODER -- requirements
Module: key_event_decoder

Interface
REQ-001 Parameter LONG_TICKS, default 100: press duration in 10 ms ticks that qualifies as a long press (1 s).
REQ-002 Parameter DBL_TICKS, default 30: maximum release gap in 10 ms ticks that still counts as a double click (300 ms).
REQ-003 Parameter RPT_TICKS, default 20: repeat interval in 10 ms ticks for long_pulse while the key stays held.
REQ-004 All parameters SHALL be in range 1..255; tick_cnt is 8 bits wide.
REQ-005 clk  input  1  system clock, single clock domain.
REQ-006 sys_rst_n  input  1  asynchronous, active-low reset.
REQ-007 ms10_tick  input  1  one-clk strobe every 10 ms.
REQ-008 key_down  input  1  debounced key level; 1 = pressed, synchronous to clk.
REQ-009 short_pulse  output  1  one-clk pulse per completed single short click.
REQ-010 double_pulse  output  1  one-clk pulse per double click.
REQ-011 long_pulse  output  1  one-clk pulse at long-press qualification and at each repeat.
REQ-012 hold_active  output  1  level; 1 while in LONG_HOLD.

Function
REQ-013 The block SHALL register key_down into key_d each clk; rise = key_down & !key_d; fall = !key_down & key_d.
REQ-014 FSM states SHALL be IDLE, PRESS1, WAIT2, PRESS2, LONG_HOLD.
REQ-015 IDLE: on rise -> PRESS1, tick_cnt <= 0; a level held high without a rise SHALL NOT leave IDLE.
REQ-016 PRESS1: each ms10_tick increments tick_cnt; on fall -> WAIT2, tick_cnt <= 0.
REQ-017 PRESS1: when a tick brings tick_cnt to LONG_TICKS with key_down=1 -> LONG_HOLD, tick_cnt <= 0, long_pulse=1 for the next cycle.
REQ-018 WAIT2: each ms10_tick increments tick_cnt; on rise -> PRESS2 and double_pulse=1 for one cycle.
REQ-019 WAIT2: when a tick brings tick_cnt to DBL_TICKS with no rise -> IDLE, short_pulse=1 for one cycle.
REQ-020 PRESS2: no long detection; on fall -> IDLE; no further pulses.
REQ-021 LONG_HOLD: each ms10_tick increments tick_cnt; at RPT_TICKS, long_pulse=1 for one cycle and tick_cnt <= 0; on fall -> IDLE.
REQ-022 Simultaneous fall and qualifying tick in the same cycle: fall SHALL win (PRESS1 -> WAIT2 with no long_pulse; LONG_HOLD -> IDLE with no repeat).
REQ-023 Simultaneous rise and DBL_TICKS expiry in WAIT2: rise SHALL win (double_pulse, no short_pulse).
REQ-024 All outputs SHALL be registered; at most one of short/double/long pulse is asserted in any cycle.
REQ-025 Each pulse SHALL be asserted in the cycle after the qualifying event (one-cycle latency).
REQ-026 tick_cnt SHALL never exceed the active threshold; it is cleared on every state change.
REQ-027 Illegal state encodings SHALL return to IDLE on the next clk.

Reset
REQ-028 While sys_rst_n=0: state=IDLE, tick_cnt=0, key_d=0, all outputs 0, independent of clk.
REQ-029 Reset mid-operation SHALL abort any pending event without emitting a pulse.
REQ-030 After reset release with key_down already 1, key_d=0 causes a rise on the first clk; a PRESS1 cycle then starts normally.

Verification
REQ-031 Press 5 ticks, release, wait 30 ticks -> exactly one short_pulse, one clk wide, in the cycle after the 30th tick.
REQ-032 Press 5 ticks, release 10 ticks, press again -> double_pulse in the cycle after the second rise; release -> no short_pulse.
REQ-033 Hold 100 ticks -> long_pulse after the 100th tick, hold_active=1; continue 40 ticks -> 2 more long_pulses spaced 20 ticks; release -> hold_active=0.
REQ-034 Release in the same cycle as the 100th tick -> no long_pulse; short_pulse 30 ticks later.
REQ-035 Assert sys_rst_n=0 during WAIT2 at tick 15 -> outputs 0 immediately; no short_pulse after release.
REQ-036 Second rise in the same cycle as the 30th WAIT2 tick -> double_pulse only.
